// File: rtl/calib_id_decoder.sv
// calib_id_decoder: rebuilds the LED ID seen at each pixel address from red/blue calibration frames.
// Optional feature macro CALIB_ID_DECODER_STATS_EN adds stat_red/stat_blue/stat_conflict class counters.

module calib_id_decoder #(
  parameter  int NUM_LEDS       = 50,
  parameter  int NUM_PIXELS     = 4096,
  parameter  int PIX_ADDR_WIDTH = 12,
  localparam int ID_WIDTH       = $clog2(NUM_LEDS),
  localparam int BIT_WIDTH      = (ID_WIDTH > 1) ? $clog2(ID_WIDTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_req,
  input  logic [BIT_WIDTH-1:0]      capture_bit,
  input  logic                      clear_req,
  input  logic                      pix_sof,
  input  logic                      pix_eof,
  input  logic                      pix_valid,
  input  logic [PIX_ADDR_WIDTH-1:0] pix_addr,
  input  logic                      pix_is_red,
  input  logic                      pix_is_blue,
  output logic                      busy,
  output logic                      capture_done,
  input  logic                      rd_en,
  input  logic [PIX_ADDR_WIDTH-1:0] rd_addr,
  output logic                      rd_data_valid,
  output logic [ID_WIDTH-1:0]       rd_id,
  output logic                      rd_id_complete
`ifdef CALIB_ID_DECODER_STATS_EN
  ,
  output logic [PIX_ADDR_WIDTH:0]   stat_red,
  output logic [PIX_ADDR_WIDTH:0]   stat_blue,
  output logic [PIX_ADDR_WIDTH:0]   stat_conflict
`endif
);

  localparam int WORD_WIDTH = 2 * ID_WIDTH;
  localparam logic [PIX_ADDR_WIDTH-1:0] CLR_LAST = PIX_ADDR_WIDTH'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_CLEARING,
    S_IDLE,
    S_ARMED,
    S_CAPTURING,
    S_DRAIN
  } state_t;

  state_t                    r_state;
  logic [PIX_ADDR_WIDTH-1:0] r_clr_cnt;
  logic [BIT_WIDTH-1:0]      r_bit;
  logic                      r_drain_cnt;
  logic                      r_capture_done;

  // Word layout: {seen_mask, id_bits}.
  logic [WORD_WIDTH-1:0]     r_mem [NUM_PIXELS];
  logic [WORD_WIDTH-1:0]     r_a_q1;
  logic [WORD_WIDTH-1:0]     r_a_q2;

  logic                      r_p1_valid;
  logic [PIX_ADDR_WIDTH-1:0] r_p1_addr;
  logic                      r_p1_red;
  logic                      r_p1_blue;
  logic                      r_p2_valid;
  logic [PIX_ADDR_WIDTH-1:0] r_p2_addr;
  logic                      r_p2_red;
  logic                      r_p2_blue;

  logic                      r_rd_v1;
  logic                      r_rd_v2;
  logic [ID_WIDTH-1:0]       r_rd_id;
  logic                      r_rd_complete;

  logic                      w_busy;
  logic                      w_accept;
  logic [PIX_ADDR_WIDTH-1:0] w_a_addr;
  logic                      w_b_we;
  logic [PIX_ADDR_WIDTH-1:0] w_b_addr;
  logic [WORD_WIDTH-1:0]     w_b_data;
  logic [WORD_WIDTH-1:0]     w_upd;

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = pix_valid &
                    (((r_state == S_ARMED) & pix_sof) | (r_state == S_CAPTURING));

  // Port A is shared: the capture pipeline owns it while busy, the read port otherwise.
  assign w_a_addr = w_busy ? pix_addr : rd_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_CLEARING;
      r_clr_cnt      <= '0;
      r_bit          <= '0;
      r_drain_cnt    <= 1'b0;
      r_capture_done <= 1'b0;
    end else begin
      r_capture_done <= 1'b0;
      case (r_state)
        S_CLEARING: begin
          r_clr_cnt <= r_clr_cnt + PIX_ADDR_WIDTH'(1);
          if (r_clr_cnt == CLR_LAST) begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            r_state   <= S_CLEARING;
            r_clr_cnt <= '0;
          end else if (capture_req) begin
            r_state <= S_ARMED;
            r_bit   <= capture_bit;
          end
        end
        S_ARMED: begin
          if (pix_valid & pix_sof) begin
            r_state     <= pix_eof ? S_DRAIN : S_CAPTURING;
            r_drain_cnt <= 1'b0;
          end
        end
        S_CAPTURING: begin
          if (pix_valid & pix_eof) begin
            r_state     <= S_DRAIN;
            r_drain_cnt <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_drain_cnt <= 1'b1;
          if (!r_drain_cnt) begin
            r_capture_done <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_CLEARING;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_valid <= 1'b0;
      r_p1_addr  <= '0;
      r_p1_red   <= 1'b0;
      r_p1_blue  <= 1'b0;
      r_p2_valid <= 1'b0;
      r_p2_addr  <= '0;
      r_p2_red   <= 1'b0;
      r_p2_blue  <= 1'b0;
    end else begin
      r_p1_valid <= w_accept;
      r_p1_addr  <= pix_addr;
      r_p1_red   <= pix_is_red;
      r_p1_blue  <= pix_is_blue;
      r_p2_valid <= r_p1_valid;
      r_p2_addr  <= r_p1_addr;
      r_p2_red   <= r_p1_red;
      r_p2_blue  <= r_p1_blue;
    end
  end

  // NOTE: RAM array and its read registers carry no reset so they map onto block RAM;
  // the CLEARING sweep is what gives the contents a defined value.
  always_ff @(posedge clk) begin
    r_a_q1 <= r_mem[w_a_addr];
    r_a_q2 <= r_a_q1;
    if (w_b_we) begin
      r_mem[w_b_addr] <= w_b_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_upd = r_a_q2;
    for (int i = 0; i < ID_WIDTH; i++) begin
      if (r_bit == BIT_WIDTH'(i)) begin
        w_upd[i]            = r_p2_blue;
        w_upd[ID_WIDTH + i] = 1'b1;
      end
    end
  end

  always_comb begin
    w_b_we   = 1'b0;
    w_b_addr = r_p2_addr;
    w_b_data = w_upd;
    if (r_state == S_CLEARING) begin
      w_b_we   = 1'b1;
      w_b_addr = r_clr_cnt;
      w_b_data = '0;
    end else if (r_p2_valid & (r_p2_red ^ r_p2_blue)) begin
      w_b_we = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_v1       <= 1'b0;
      r_rd_v2       <= 1'b0;
      r_rd_id       <= '0;
      r_rd_complete <= 1'b0;
    end else begin
      r_rd_v1 <= rd_en & ~w_busy;
      r_rd_v2 <= r_rd_v1;
      if (r_rd_v1) begin
        r_rd_id       <= r_a_q1[ID_WIDTH-1:0];
        r_rd_complete <= &r_a_q1[WORD_WIDTH-1:ID_WIDTH];
      end
    end
  end

  assign busy           = w_busy;
  assign capture_done   = r_capture_done;
  assign rd_data_valid  = r_rd_v2;
  assign rd_id          = r_rd_id;
  assign rd_id_complete = r_rd_complete;

`ifdef CALIB_ID_DECODER_STATS_EN
  localparam int STAT_WIDTH = PIX_ADDR_WIDTH + 1;

  logic [STAT_WIDTH-1:0] r_stat_red;
  logic [STAT_WIDTH-1:0] r_stat_blue;
  logic [STAT_WIDTH-1:0] r_stat_conflict;

  // Counters restart when a capture is armed and hold their totals until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_red      <= '0;
      r_stat_blue     <= '0;
      r_stat_conflict <= '0;
    end else if ((r_state == S_IDLE) & ~clear_req & capture_req) begin
      r_stat_red      <= '0;
      r_stat_blue     <= '0;
      r_stat_conflict <= '0;
    end else if (w_accept) begin
      if (pix_is_red & ~pix_is_blue & (r_stat_red != '1)) begin
        r_stat_red <= r_stat_red + STAT_WIDTH'(1);
      end
      if (pix_is_blue & ~pix_is_red & (r_stat_blue != '1)) begin
        r_stat_blue <= r_stat_blue + STAT_WIDTH'(1);
      end
      if (pix_is_red & pix_is_blue & (r_stat_conflict != '1)) begin
        r_stat_conflict <= r_stat_conflict + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_red      = r_stat_red;
  assign stat_blue     = r_stat_blue;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule
